led_stripe_decoder: RTL

//  Single-wire NRZ (WS2812-style) receiver: decodes the pulse stream on led_stripe_pin

---
 rtl/led_stripe_if.sv | 29 ++
 rtl/led_stripe_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/led_stripe_if.sv
`default_nettype none
// ============================================================================
// Module      : led_stripe_if
// Description : Word handshake bundle between the LED stripe decoder and its
//               consumer (decoded colour word, valid, ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface led_stripe_if #(
    parameter int BITS_PER_LED = 24
);
    logic [BITS_PER_LED-1:0] data_out;
    logic                    data_valid;
    logic                    data_ready;

    // Decoder side produces words
    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    // Consumer side accepts words
    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface
`default_nettype wire

// File: rtl/led_stripe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : led_stripe_decoder
// Description : Single-wire NRZ (WS2812-style) receiver. Measures high-pulse
//               widths on the synchronised line, shifts decoded bits MSB
//               first into colour words, hands words out over valid/ready
//               and flags frame ends on the long low reset gap.
// Revision    : 1.0 - initial release
// ============================================================================
module led_stripe_decoder #(
    parameter int BITS_PER_LED = 24,
    parameter int MIN_HIGH     = 4,
    parameter int BIT_THRESH   = 15,
    parameter int MAX_HIGH     = 40,
    parameter int RESET_CYC    = 1250
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         led_stripe_pin,
    led_stripe_if.master bus,
    output logic         frame_end,
    output logic [15:0]  led_count,
    output logic         pulse_error
);

    localparam int c_hcnt_w = $clog2(MAX_HIGH + 1);
    localparam int c_lcnt_w = $clog2(RESET_CYC + 1);
    localparam int c_bcnt_w = $clog2(BITS_PER_LED + 1);

    localparam logic [c_hcnt_w-1:0] c_hcnt_one  = c_hcnt_w'(1);
    localparam logic [c_hcnt_w-1:0] c_hcnt_min  = c_hcnt_w'(MIN_HIGH);
    localparam logic [c_hcnt_w-1:0] c_hcnt_thr  = c_hcnt_w'(BIT_THRESH);
    localparam logic [c_hcnt_w-1:0] c_hcnt_last = c_hcnt_w'(MAX_HIGH - 1);
    localparam logic [c_hcnt_w-1:0] c_hcnt_max  = c_hcnt_w'(MAX_HIGH);
    localparam logic [c_lcnt_w-1:0] c_lcnt_one  = c_lcnt_w'(1);
    localparam logic [c_lcnt_w-1:0] c_lcnt_last = c_lcnt_w'(RESET_CYC - 1);
    localparam logic [c_lcnt_w-1:0] c_lcnt_full = c_lcnt_w'(RESET_CYC);
    localparam logic [c_bcnt_w-1:0] c_bcnt_one  = c_bcnt_w'(1);
    localparam logic [c_bcnt_w-1:0] c_bcnt_full = c_bcnt_w'(BITS_PER_LED);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_sync_meta;
    logic                    r_ls;
    logic                    r_ls_d;
    logic [c_hcnt_w-1:0]     r_hcnt;
    logic [c_lcnt_w-1:0]     r_lcnt;
    logic [c_bcnt_w-1:0]     r_bcnt;
    logic [BITS_PER_LED-1:0] r_shift;
    logic [BITS_PER_LED-1:0] r_data_out;
    logic                    r_data_valid;
    logic                    r_frame_end;
    logic                    r_pulse_error;
    logic [15:0]             r_led_count;
    logic                    r_new_frame;   // next decoded bit starts a fresh frame

    logic w_rise;
    logic w_fall;

    // Two-flop synchroniser for the asynchronous line plus a delay tap for edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_ls        <= 1'b0;
            r_ls_d      <= 1'b0;
        end else begin
            r_sync_meta <= led_stripe_pin;
            r_ls        <= r_sync_meta;
            r_ls_d      <= r_ls;
        end
    end

    assign w_rise = r_ls & ~r_ls_d;
    assign w_fall = ~r_ls & r_ls_d;

    // Pulse-width FSM, bit shifter, word commit and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_SYNC;
            r_hcnt        <= '0;
            r_lcnt        <= '0;
            r_bcnt        <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_end   <= 1'b0;
            r_pulse_error <= 1'b0;
            r_led_count   <= '0;
            r_new_frame   <= 1'b0;
        end else begin
            r_frame_end   <= 1'b0;
            r_pulse_error <= 1'b0;

            if (r_data_valid && bus.data_ready) begin
                r_data_valid <= 1'b0;
            end

            case (r_state)
                S_SYNC: begin
                    // Any high restarts the hunt for a full reset gap
                    r_hcnt <= '0;
                    if (r_ls) begin
                        r_lcnt <= '0;
                    end else if (r_lcnt >= c_lcnt_last) begin
                        r_lcnt      <= '0;
                        r_new_frame <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_lcnt <= r_lcnt + c_lcnt_one;
                    end
                end

                S_IDLE: begin
                    if (w_rise) begin
                        r_hcnt  <= c_hcnt_one;
                        r_state <= S_HIGH;
                    end
                end

                S_HIGH: begin
                    if (w_fall) begin
                        r_lcnt  <= c_lcnt_one;
                        r_state <= S_LOW;
                        if (r_hcnt < c_hcnt_min) begin
                            r_pulse_error <= 1'b1;
                        end else begin
                            r_shift <= {r_shift[BITS_PER_LED-2:0], (r_hcnt >= c_hcnt_thr)};
                            if (r_bcnt != c_bcnt_full) begin
                                r_bcnt <= r_bcnt + c_bcnt_one;
                            end
                            if (r_new_frame) begin
                                r_led_count <= '0;
                                r_new_frame <= 1'b0;
                            end
                        end
                    end else if (r_hcnt >= c_hcnt_last) begin
                        // Over-long high: drop the partial word and resynchronise
                        r_hcnt        <= c_hcnt_max;
                        r_pulse_error <= 1'b1;
                        r_shift       <= '0;
                        r_bcnt        <= '0;
                        r_lcnt        <= '0;
                        r_state       <= S_SYNC;
                    end else begin
                        r_hcnt <= r_hcnt + c_hcnt_one;
                    end
                end

                S_LOW: begin
                    if (w_rise) begin
                        r_hcnt  <= c_hcnt_one;
                        r_state <= S_HIGH;
                    end else if (r_lcnt >= c_lcnt_last) begin
                        r_lcnt      <= c_lcnt_full;
                        r_frame_end <= 1'b1;
                        r_new_frame <= 1'b1;
                        r_state     <= S_IDLE;
                        if (r_bcnt != '0) begin
                            r_pulse_error <= 1'b1;
                            r_bcnt        <= '0;
                        end
                    end else begin
                        r_lcnt <= r_lcnt + c_lcnt_one;
                    end
                end

                default: begin
                    r_state <= S_SYNC;
                end
            endcase

            // A full word was shifted in last cycle: hand it out or flag overflow
            if (r_bcnt == c_bcnt_full) begin
                r_bcnt <= '0;
                if (r_led_count != 16'hFFFF) begin
                    r_led_count <= r_led_count + 16'd1;
                end
                if (r_data_valid && !bus.data_ready) begin
                    r_pulse_error <= 1'b1;
                end else begin
                    r_data_out   <= r_shift;
                    r_data_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign frame_end      = r_frame_end;
    assign led_count      = r_led_count;
    assign pulse_error    = r_pulse_error;

endmodule
`default_nettype wire
